// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the requester blocks and the round-robin grant controller.
// master = requester side (drives req), slave = controller side (drives grant outputs).
interface rr_grant_ctrl_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) ();

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             busy;
   logic             preempt;

   modport master (
      output req,
      input  gnt,
      input  gnt_id,
      input  busy,
      input  preempt
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_id,
      output busy,
      output preempt
   );

endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: rotating priority, bounded hold quantum while others wait,
// and a single dead cycle on the bus between consecutive owners. All outputs registered.
module rr_grant_ctrl #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input logic         clk,
   input logic         n_rst,
   rr_grant_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             busy_q, busy_d;
   logic             preempt_q, preempt_d;

   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  scan_id;
   logic             owner_req;
   logic             others_req;
   logic             quantum_hit;

   // Rotating search: first set req bit starting just after the last owner, wrapping to 0.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_id   = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         scan_id = ID_W'((32'(last_q) + i) % N_REQ);
         if (!win_found && bus.req[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   assign owner_req  = bus.req[gnt_id_q];
   assign others_req = (bus.req & ~gnt_q) != '0;
   // >= rather than == so a newcomer arriving after the counter saturated still gets a turn.
   assign quantum_hit = (MAX_HOLD != 0) && (hold_cnt_q >= HoldLast);

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      busy_d     = busy_q;
      preempt_d  = 1'b0;

      case (state_q)
         StIdle, StRelease: begin
            // RELEASE samples req on its closing edge, so handover costs exactly one zero cycle.
            if (win_found) begin
               state_d         = StGrant;
               gnt_d           = '0;
               gnt_d[win_id]   = 1'b1;
               gnt_id_d        = win_id;
               last_d          = win_id;
               hold_cnt_d      = '0;
               busy_d          = 1'b1;
            end else begin
               state_d = StIdle;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         StGrant: begin
            if (hold_cnt_q != HoldMax) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (!owner_req) begin
               state_d = StRelease;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end else if (quantum_hit && others_req) begin
               state_d   = StRelease;
               gnt_d     = '0;
               busy_d    = 1'b0;
               preempt_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears the grant immediately, even mid-ownership.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         last_q     <= ID_W'(N_REQ - 1);
         hold_cnt_q <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         busy_q     <= busy_d;
         preempt_q  <= preempt_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.busy    = busy_q;
   assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed scenarios followed by random request traffic, every cycle
// checked against an ownership-level reference model.
module tb_rr_grant_ctrl;

   localparam int N    = 4;
   localparam int HOLD = 8;

   logic clk;
   logic n_rst;

   rr_grant_ctrl_if #(.N_REQ(4), .ID_W(2)) bus ();

   rr_grant_ctrl #(
      .N_REQ(4),
      .ID_W(2),
      .MAX_HOLD(8),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: who owns the bus, for how many cycles, and who owned it last.
   int m_owner;   // -1 when nobody owns the bus (idle or dead cycle)
   int m_held;    // cycles of ownership already completed
   int m_last;
   int m_id;
   bit m_pre;

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
      m_id    = 0;
      m_pre   = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r);
      logic [3:0] others;
      int idx;
      m_pre = 1'b0;
      if (m_owner >= 0) begin
         others = r & ~(4'b0001 << m_owner);
         if (!r[m_owner]) begin
            m_owner = -1;
         end else if (m_held >= HOLD && others != 4'b0000) begin
            m_owner = -1;
            m_pre   = 1'b1;
         end else begin
            m_held++;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (m_owner < 0 && r[idx]) begin
               m_owner = idx;
               m_held  = 1;
               m_last  = idx;
               m_id    = idx;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] eg;
      logic [1:0] eid;
      logic       eb;
      eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      eid = 2'(m_id);
      eb  = (m_owner >= 0);
      n_cmp++;
      assert (bus.gnt === eg) else begin
         n_bad++;
         $error("FAIL %s gnt: got %b want %b", tag, bus.gnt, eg);
      end
      n_cmp++;
      assert (bus.gnt_id === eid) else begin
         n_bad++;
         $error("FAIL %s gnt_id: got %0d want %0d", tag, bus.gnt_id, eid);
      end
      n_cmp++;
      assert (bus.busy === eb) else begin
         n_bad++;
         $error("FAIL %s busy: got %b want %b", tag, bus.busy, eb);
      end
      n_cmp++;
      assert (bus.preempt === m_pre) else begin
         n_bad++;
         $error("FAIL %s preempt: got %b want %b", tag, bus.preempt, m_pre);
      end
   endtask

   // One clock: drive req just after an edge, let the next edge sample it, check 1 time unit later.
   task automatic cycle(input logic [3:0] r, input string tag);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      #1;
      check_all(tag);
   endtask

   task automatic apply_reset(input string tag);
      n_rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      check_all(tag);
   endtask

   logic [3:0] rnd;

   initial begin
      n_rst   = 1'b0;
      bus.req = 4'b0000;
      #1;
      model_reset();
      check_all("por");
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      // Reset/idle
      repeat (5) cycle(4'b0000, "idle");

      // Single request held three cycles, then dropped
      repeat (3) cycle(4'b0100, "single");
      repeat (3) cycle(4'b0000, "single_drop");

      // Async reset in the middle of a grant
      repeat (2) cycle(4'b0010, "pre_rst");
      n_cmp++;
      assert (bus.gnt === 4'b0010) else begin
         n_bad++;
         $error("FAIL pre_rst_own: got %b want %b", bus.gnt, 4'b0010);
      end
      apply_reset("mid_rst");
      cycle(4'b0000, "post_rst");

      // All requesting: quantum-driven rotation 0,1,2,3,0
      repeat (46) cycle(4'b1111, "rr_all");
      repeat (3) cycle(4'b0000, "rr_drain");

      // Lone requester far beyond the quantum
      repeat (20) cycle(4'b0010, "lone");
      // Newcomer after the counter saturated still forces a release
      repeat (4) cycle(4'b0011, "late_join");
      repeat (3) cycle(4'b0000, "lone_drain");

      // Coincident owner drop and quantum expiry: no preempt
      apply_reset("rst_coinc");
      repeat (8) cycle(4'b0101, "coinc_hold");
      cycle(4'b0100, "coinc_drop");
      n_cmp++;
      assert (bus.preempt === 1'b0 && bus.gnt === 4'b0000) else begin
         n_bad++;
         $error("FAIL coinc_dead: got pre=%b gnt=%b want pre=0 gnt=0000", bus.preempt, bus.gnt);
      end
      cycle(4'b0100, "coinc_next");
      n_cmp++;
      assert (bus.gnt === 4'b0100) else begin
         n_bad++;
         $error("FAIL coinc_next_own: got %b want %b", bus.gnt, 4'b0100);
      end
      repeat (3) cycle(4'b0000, "coinc_drain");

      // Wrap-around fairness from last=3
      apply_reset("rst_wrap");
      cycle(4'b1001, "wrap_first");
      n_cmp++;
      assert (bus.gnt === 4'b0001) else begin
         n_bad++;
         $error("FAIL wrap_first_own: got %b want %b", bus.gnt, 4'b0001);
      end
      repeat (12) cycle(4'b1001, "wrap_hold");
      n_cmp++;
      assert (bus.gnt === 4'b1000) else begin
         n_bad++;
         $error("FAIL wrap_second_own: got %b want %b", bus.gnt, 4'b1000);
      end
      repeat (3) cycle(4'b0000, "wrap_drain");

      // Request glitch entirely inside the dead cycle is never granted
      repeat (2) cycle(4'b0001, "gl_own");
      cycle(4'b0000, "gl_release");
      bus.req = 4'b0010;
      #3;
      bus.req = 4'b0000;
      @(posedge clk);
      model_step(4'b0000);
      #1;
      check_all("gl_dead");
      repeat (3) cycle(4'b0000, "gl_after");

      // Random traffic: requests toggle occasionally so grants are held for varying spans
      rnd = 4'b0000;
      repeat (600) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 7) == 0) rnd[b] = ~rnd[b];
         end
         cycle(rnd, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
